// File: rtl/frame_scroller.sv
// Frame scroller: a 7-column window over a fixed glyph ROM message, advanced
// on a prescaled tick and steered by two synchronized mode switches.
module frame_scroller #(
  parameter int unsigned DIV      = 12500000,
  parameter int unsigned MSG_COLS = 32
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ch0,
  input  logic        ch1,
  output logic [34:0] frame,
  output logic        step
);

  localparam int unsigned CntW    = $clog2(DIV);
  localparam logic [CntW-1:0] CntLast = CntW'(DIV - 1);
  localparam logic [5:0] Cols6    = 6'(MSG_COLS);
  localparam logic [4:0] LastCol  = 5'(MSG_COLS - 1);

  typedef enum logic [1:0] {
    ModeHold  = 2'b00,
    ModeLeft  = 2'b01,
    ModeRight = 2'b10,
    ModeBlink = 2'b11
  } mode_e;

  logic [1:0]      sync1_q, sync2_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tick;
  logic [4:0]      ptr_q, ptr_d;
  logic            phase_q, phase_d;
  logic [34:0]     frame_q, frame_d;
  logic            step_q, step_d;
  mode_e           mode;

  // Message glyphs, one column per index, bit 0 is the top row.
  function automatic logic [4:0] rom_col(input logic [4:0] idx);
    logic [4:0] col;
    case (idx)
      5'd7, 5'd11:              col = 5'h0E;
      5'd8, 5'd9, 5'd10:        col = 5'h11;
      5'd13:                    col = 5'h1F;
      5'd14, 5'd15, 5'd16:      col = 5'h10;
      5'd18, 5'd21:             col = 5'h1E;
      5'd19, 5'd20:             col = 5'h05;
      default:                  col = 5'h00;
    endcase
    return col;
  endfunction

  // ptr < MSG_COLS and offset <= 6 < MSG_COLS, so one subtraction suffices.
  function automatic logic [4:0] wrap_idx(input logic [5:0] sum);
    logic [5:0] r;
    r = (sum >= Cols6) ? (sum - Cols6) : sum;
    return r[4:0];
  endfunction

  function automatic logic [34:0] window(input logic [4:0] p);
    logic [34:0] w;
    w = '0;
    for (int c = 0; c < 7; c++) begin
      w[c*5 +: 5] = rom_col(wrap_idx({1'b0, p} + 6'(c)));
    end
    return w;
  endfunction

  assign mode = mode_e'(sync2_q);
  assign tick = (cnt_q == CntLast);

  // Two-flop synchronizer for the asynchronous mode switches.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
    end else begin
      sync1_q <= {ch1, ch0};
      sync2_q <= sync1_q;
    end
  end

  // Free-running step prescaler.
  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  // Pointer, blink phase and frame update on each tick.
  always_comb begin
    ptr_d   = ptr_q;
    phase_d = phase_q;
    frame_d = frame_q;
    step_d  = 1'b0;
    if (tick) begin
      step_d = 1'b1;
      unique case (mode)
        ModeHold:  ptr_d = ptr_q;
        ModeLeft:  ptr_d = (ptr_q == LastCol) ? 5'd0 : ptr_q + 5'd1;
        ModeRight: ptr_d = (ptr_q == 5'd0) ? LastCol : ptr_q - 5'd1;
        ModeBlink: phase_d = ~phase_q;
        default:   ptr_d = ptr_q;
      endcase
      // Leaving blink clears the phase so the next entry starts blank.
      if (mode != ModeBlink) phase_d = 1'b0;
      frame_d = phase_d ? '0 : window(ptr_d);
    end
  end

  // State registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q   <= '0;
      ptr_q   <= 5'd0;
      phase_q <= 1'b0;
      frame_q <= '0;
      step_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      phase_q <= phase_d;
      frame_q <= frame_d;
      step_q  <= step_d;
    end
  end

  assign frame = frame_q;
  assign step  = step_q;

endmodule
